// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Captures ALU results into a 2-entry skid buffer and retires them in order
// to the register-file write port. It also keeps the architectural NZCV
// flags and evaluates branch conditions against those flags.
// Only retired entries ever touch the flags. Buffered entries are invisible
// to the branch unit until they retire.
module alu_writeback_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              in_carry,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              in_flag_en,
    input  logic              out_ready,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              overflow;
        logic              carry;
        logic [RD_W-1:0]   rd;
        logic              wr_en;
        logic              flag_en;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    entry_t             slot_reg  [2];
    entry_t             slot_next [2];
    entry_t             incoming;
    entry_t             head;
    logic               wr_idx;
    logic               in_ready_reg;
    logic [3:0]         flags_reg, flags_next;
    logic [CNT_W-1:0]   retire_cnt_reg;
    logic               accept;
    logic               retire;

    // Handshake terms. Slot 0 is always the head.
    assign head     = slot_reg[0];
    assign wb_valid = (state_reg != EMPTY);
    assign accept   = in_valid & in_ready_reg;
    assign retire   = wb_valid & out_ready;

    assign in_ready   = in_ready_reg;
    assign wb_we      = retire & head.wr_en;
    assign wb_rd      = head.rd;
    assign wb_data    = head.result;
    assign flags      = flags_reg;
    assign retire_cnt = retire_cnt_reg;

    // Pack the ALU outputs into a buffer entry.
    always_comb begin
        incoming          = '0;
        incoming.result   = in_result;
        incoming.zero     = in_zero;
        incoming.overflow = in_overflow;
        incoming.carry    = in_carry;
        incoming.rd       = in_rd;
        incoming.wr_en    = in_wr_en;
        incoming.flag_en  = in_flag_en;
    end

    // Occupancy FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) state_next = ONE;
            end
            ONE: begin
                if (accept && !retire)      state_next = FULL;
                else if (!accept && retire) state_next = EMPTY;
            end
            FULL: begin
                if (retire) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Slot update. A retire shifts the second entry into the head and
    // clears the vacated slot, so the empty outputs read as zero. An
    // accepted entry then lands in the first free slot after that shift.
    always_comb begin
        slot_next[0] = slot_reg[0];
        slot_next[1] = slot_reg[1];
        wr_idx       = 1'b0;
        if (retire) begin
            slot_next[0] = slot_reg[1];
            slot_next[1] = '0;
        end
        if (state_reg == ONE && !retire) begin
            wr_idx = 1'b1;
        end
        if (accept) begin
            if (wr_idx) slot_next[1] = incoming;
            else        slot_next[0] = incoming;
        end
    end

    // The flags change only when an entry that carries flag_en retires.
    always_comb begin
        flags_next = flags_reg;
        if (retire && head.flag_en) begin
            flags_next = {head.result[DATA_W-1], head.zero, head.carry, head.overflow};
        end
    end

    // Branch condition evaluated on the architectural flags {N,Z,C,V}.
    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags_reg[2];
            3'd2: cond_true = ~flags_reg[2];
            3'd3: cond_true = flags_reg[1];
            3'd4: cond_true = ~flags_reg[1];
            3'd5: cond_true = flags_reg[3];
            3'd6: cond_true = flags_reg[0];
            3'd7: cond_true = flags_reg[3] ~^ flags_reg[0];
            default: cond_true = 1'b1;
        endcase
    end

    // State, storage, flags and the counter. Reset drops everything in flight.
    // in_ready is registered from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= EMPTY;
            slot_reg[0]    <= '0;
            slot_reg[1]    <= '0;
            in_ready_reg   <= 1'b0;
            flags_reg      <= 4'b0000;
            retire_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            slot_reg[0]  <= slot_next[0];
            slot_reg[1]  <= slot_next[1];
            in_ready_reg <= (state_next != FULL);
            flags_reg    <= flags_next;
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
